// File: rtl/vote_pkg.sv
// Shared types and constants for the vote tally arbiter.
package vote_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCommit = 2'd1,
    StAck    = 2'd2
  } vote_state_e;

  localparam logic CAND_RED  = 1'b0;
  localparam logic CAND_BLUE = 1'b1;

  localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] pointer,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  localparam logic [IDX_W:0] NumW = (IDX_W + 1)'(N);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Wrap pointer + k into 0..N-1 without a modulo operator.
      sum = {1'b0, pointer} + (IDX_W + 1)'(k);
      if (sum >= NumW) begin
        sum = sum - NumW;
      end
      idx = sum[IDX_W-1:0];
      if (!valid && eligible[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vote_tally_arbiter.sv
// Round-robin arbiter that commits one booth's vote at a time to shared saturating
// red/blue/total tallies and returns a one-cycle acknowledge.
module vote_tally_arbiter
  import vote_pkg::*;
#(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W,
  parameter int unsigned ID_W       = $clog2(NUM_BOOTHS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_BOOTHS-1:0] req,
  input  logic [NUM_BOOTHS-1:0] cand,
  input  logic                  freeze,
  output logic [NUM_BOOTHS-1:0] ack,
  output logic [ID_W-1:0]       grant_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      count_r,
  output logic [CNT_W-1:0]      count_b,
  output logic [CNT_W-1:0]      count_t,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [ID_W-1:0]  LastId  = ID_W'(NUM_BOOTHS - 1);

  vote_state_e           state_q;
  logic                  cand_q;
  logic [NUM_BOOTHS-1:0] wait_low_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       grant_q;
  logic [NUM_BOOTHS-1:0] ack_q;
  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_r_q;
  logic [CNT_W-1:0]      cnt_b_q;
  logic [CNT_W-1:0]      cnt_t_q;
  logic                  ovf_q;

  logic [NUM_BOOTHS-1:0] eligible;
  logic [ID_W-1:0]       win_id;
  logic                  win_valid;
  logic [NUM_BOOTHS-1:0] grant_oh;
  logic [ID_W-1:0]       next_ptr;
  logic                  r_full;
  logic                  b_full;
  logic                  t_full;
  logic                  sel_full;

  assign eligible = req & ~wait_low_q;
  assign grant_oh = NUM_BOOTHS'(1) << grant_q;
  assign next_ptr = (grant_q == LastId) ? '0 : grant_q + ID_W'(1);
  assign r_full   = (cnt_r_q == CntMax);
  assign b_full   = (cnt_b_q == CntMax);
  assign t_full   = (cnt_t_q == CntMax);
  assign sel_full = (cand_q == CAND_RED) ? r_full : b_full;

  rr_arbiter #(
    .N     (NUM_BOOTHS),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .eligible (eligible),
    .pointer  (ptr_q),
    .winner   (win_id),
    .valid    (win_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cand_q     <= CAND_RED;
      wait_low_q <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      busy_q     <= 1'b0;
      cnt_r_q    <= '0;
      cnt_b_q    <= '0;
      cnt_t_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      // A low request always clears the hold-off, even on the commit edge.
      wait_low_q <= wait_low_q & req;
      case (state_q)
        StIdle: begin
          if (!freeze && win_valid) begin
            grant_q <= win_id;
            cand_q  <= cand[win_id];
            busy_q  <= 1'b1;
            state_q <= StCommit;
          end
        end
        StCommit: begin
          if (cand_q == CAND_RED) begin
            if (!r_full) cnt_r_q <= cnt_r_q + CNT_W'(1);
          end else begin
            if (!b_full) cnt_b_q <= cnt_b_q + CNT_W'(1);
          end
          if (!t_full) cnt_t_q <= cnt_t_q + CNT_W'(1);
          ovf_q      <= ovf_q | sel_full | t_full;
          ack_q      <= grant_oh;
          wait_low_q <= (wait_low_q | grant_oh) & req;
          ptr_q      <= next_ptr;
          state_q    <= StAck;
        end
        StAck: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign count_r  = cnt_r_q;
  assign count_b  = cnt_b_q;
  assign count_t  = cnt_t_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_vote_tally_arbiter.sv
// Bench for vote_tally_arbiter: directed table, corner sequences, and random traffic
// against a behavioural model; a narrow-counter instance exercises saturation.
module tb_vote_tally_arbiter;

  localparam int N    = 4;
  localparam int MAXW = 65535;
  localparam int MAXS = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  cand;
  logic        freeze;

  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] count_r, count_b, count_t;
  logic        overflow;

  logic [3:0]  s_ack;
  logic [1:0]  s_grant_id;
  logic        s_busy;
  logic [2:0]  s_count_r, s_count_b, s_count_t;
  logic        s_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vote_tally_arbiter #(
    .NUM_BOOTHS (4),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cand     (cand),
    .freeze   (freeze),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .count_r  (count_r),
    .count_b  (count_b),
    .count_t  (count_t),
    .overflow (overflow)
  );

  vote_tally_arbiter #(
    .NUM_BOOTHS (4),
    .CNT_W      (3)
  ) sdut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cand     (cand),
    .freeze   (freeze),
    .ack      (s_ack),
    .grant_id (s_grant_id),
    .busy     (s_busy),
    .count_r  (s_count_r),
    .count_b  (s_count_b),
    .count_t  (s_count_t),
    .overflow (s_overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  int   m_phase, m_grant, m_candq, m_ptr, m_pick;
  int   m_r, m_b, m_t, s_r, s_b, s_t;
  bit   m_ovf, s_ovf;
  logic [3:0] m_wl, m_ack;

  function automatic bit bit_at(input logic [3:0] v, input int i);
    return v[i[1:0]];
  endfunction

  function automatic void bump(inout int v, input int maxv, inout bit ovf);
    if (v == maxv) ovf = 1'b1;
    else v = v + 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_grant = 0; m_candq = 0; m_ptr = 0;
      m_wl = '0; m_ack = '0;
      m_r = 0; m_b = 0; m_t = 0; m_ovf = 1'b0;
      s_r = 0; s_b = 0; s_t = 0; s_ovf = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_pick = -1;
          if (!freeze) begin
            for (int k = N - 1; k >= 0; k--) begin
              if (bit_at(req, (m_ptr + k) % N) && !bit_at(m_wl, (m_ptr + k) % N))
                m_pick = (m_ptr + k) % N;
            end
          end
          if (m_pick >= 0) begin
            m_grant = m_pick;
            m_candq = int'(bit_at(cand, m_pick));
            m_phase = 1;
          end
        end
        1: begin
          if (m_candq == 0) begin
            bump(m_r, MAXW, m_ovf);
            bump(s_r, MAXS, s_ovf);
          end else begin
            bump(m_b, MAXW, m_ovf);
            bump(s_b, MAXS, s_ovf);
          end
          bump(m_t, MAXW, m_ovf);
          bump(s_t, MAXS, s_ovf);
          m_ack   = 4'b1 << m_grant;
          m_wl    = m_wl | m_ack;
          m_ptr   = (m_grant + 1) % N;
          m_phase = 2;
        end
        default: begin
          m_ack   = '0;
          m_phase = 0;
        end
      endcase
      m_wl = m_wl & req;
    end
  end

  task automatic check_model();
    chk("m_ack", int'(ack), int'(m_ack));
    chk("m_busy", int'(busy), int'(m_phase != 0));
    if (m_phase != 0) chk("m_grant_id", int'(grant_id), m_grant);
    chk("m_count_r", int'(count_r), m_r);
    chk("m_count_b", int'(count_b), m_b);
    chk("m_count_t", int'(count_t), m_t);
    chk("m_overflow", int'(overflow), int'(m_ovf));
    chk("s_ack", int'(s_ack), int'(m_ack));
    chk("s_count_r", int'(s_count_r), s_r);
    chk("s_count_b", int'(s_count_b), s_b);
    chk("s_count_t", int'(s_count_t), s_t);
    chk("s_overflow", int'(s_overflow), int'(s_ovf));
  endtask

  // ---------------- helpers for hand sequences ----------------
  task automatic do_reset();
    reset = 1'b1; req = '0; cand = '0; freeze = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(output int b);
    b = -1;
    for (int i = 0; i < 12 && b < 0; i++) begin
      step();
      for (int j = 0; j < N; j++) if (ack == (4'b1 << j)) b = j;
    end
    chk("ack_seen", int'(b >= 0), 1);
  endtask

  task automatic vote(input int booth, input logic c);
    int b;
    req  = req | (4'b1 << booth);
    cand = (cand & ~(4'b1 << booth)) | ({3'b0, c} << booth);
    wait_ack(b);
    req = req & ~(4'b1 << booth);
    step();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  cand;
    logic        frz;
    logic [3:0]  ack;
    logic        busy;
    logic [1:0]  gid;
    logic [15:0] r;
    logic [15:0] b;
    logic [15:0] t;
  } vec_t;

  vec_t tbl[26];

  initial begin
    int b;
    int order[3];

    tbl[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 1'b1, 2'd2, 16'd0, 16'd0, 16'd0};
    tbl[2]  = '{1'b0, 4'h4, 4'h4, 1'b0, 4'h4, 1'b1, 2'd2, 16'd0, 16'd1, 16'd1};
    for (int i = 3; i < 8; i++)
      tbl[i] = '{1'b0, 4'h4, 4'h4, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0, 16'd1, 16'd1};
    tbl[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0, 16'd1, 16'd1};
    tbl[9]  = '{1'b0, 4'h4, 4'h0, 1'b0, 4'h0, 1'b1, 2'd2, 16'd0, 16'd1, 16'd1};
    tbl[10] = '{1'b0, 4'h4, 4'h0, 1'b0, 4'h4, 1'b1, 2'd2, 16'd1, 16'd1, 16'd2};
    tbl[11] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'd1, 16'd1, 16'd2};
    tbl[12] = '{1'b0, 4'h1, 4'h1, 1'b0, 4'h0, 1'b1, 2'd0, 16'd1, 16'd1, 16'd2};
    tbl[13] = '{1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 2'd0, 16'd0, 16'd0, 16'd0};
    tbl[14] = '{1'b0, 4'hA, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 16'd0, 16'd0, 16'd0};
    tbl[15] = '{1'b0, 4'hA, 4'h0, 1'b0, 4'h2, 1'b1, 2'd1, 16'd1, 16'd0, 16'd1};
    tbl[16] = '{1'b0, 4'h8, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'd1, 16'd0, 16'd1};
    tbl[17] = '{1'b0, 4'h8, 4'h0, 1'b0, 4'h0, 1'b1, 2'd3, 16'd1, 16'd0, 16'd1};
    tbl[18] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h8, 1'b1, 2'd3, 16'd2, 16'd0, 16'd2};
    tbl[19] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd2};
    tbl[20] = '{1'b0, 4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd2};
    tbl[21] = '{1'b0, 4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd2};
    tbl[22] = '{1'b0, 4'h2, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 16'd2, 16'd0, 16'd2};
    tbl[23] = '{1'b0, 4'h2, 4'h0, 1'b1, 4'h2, 1'b1, 2'd1, 16'd3, 16'd0, 16'd3};
    tbl[24] = '{1'b0, 4'h2, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 16'd3, 16'd0, 16'd3};
    tbl[25] = '{1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 16'd3, 16'd0, 16'd3};

    reset = 1'b1; req = '0; cand = '0; freeze = 1'b0;
    step();
    step();
    chk("reset_overflow", int'(overflow), 0);

    for (int i = 0; i < 26; i++) begin
      reset  = tbl[i].rst;
      req    = tbl[i].req;
      cand   = tbl[i].cand;
      freeze = tbl[i].frz;
      step();
      chk($sformatf("tbl%0d_ack", i), int'(ack), int'(tbl[i].ack));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      if (tbl[i].busy) chk($sformatf("tbl%0d_gid", i), int'(grant_id), int'(tbl[i].gid));
      chk($sformatf("tbl%0d_r", i), int'(count_r), int'(tbl[i].r));
      chk($sformatf("tbl%0d_b", i), int'(count_b), int'(tbl[i].b));
      chk($sformatf("tbl%0d_t", i), int'(count_t), int'(tbl[i].t));
    end

    // Round-robin order with three simultaneous requesters.
    do_reset();
    req = 4'b1011; cand = '0;
    for (int n = 0; n < 3; n++) begin
      wait_ack(b);
      order[n] = b;
      req = req & ~(4'b1 << (b < 0 ? 0 : b));
      step();
      chk("rr_ack_one_cycle", int'(ack), 0);
    end
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 3);
    chk("rr_count_r", int'(count_r), 3);
    chk("rr_count_t", int'(count_t), 3);
    req = 4'b1111;
    step();
    chk("rr_ptr_wrap_gid", int'(grant_id), 0);
    req = '0;
    step();
    step();

    // Freeze holds off a pending request indefinitely.
    do_reset();
    freeze = 1'b1; req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("frz_no_busy", int'(busy | (|ack)), 0);
    end
    chk("frz_count_t", int'(count_t), 0);
    freeze = 1'b0;
    step();
    step();
    chk("frz_release_ack", int'(ack), 2);
    chk("frz_release_t", int'(count_t), 1);
    req = '0;
    step();

    // Candidate changes during commit: latched value counts.
    do_reset();
    req = 4'b0001; cand = 4'b0000;
    step();
    cand = 4'b0001;
    step();
    chk("latch_ack", int'(ack), 1);
    chk("latch_r", int'(count_r), 1);
    chk("latch_b", int'(count_b), 0);
    req = '0;
    step();

    // Saturation on the narrow instance.
    do_reset();
    for (int i = 0; i < 7; i++) vote(0, 1'b0);
    chk("sat7_r", int'(s_count_r), 7);
    chk("sat7_ovf", int'(s_overflow), 0);
    vote(0, 1'b0);
    chk("sat8_r", int'(s_count_r), 7);
    chk("sat8_t", int'(s_count_t), 7);
    chk("sat8_ovf", int'(s_overflow), 1);
    chk("wide8_r", int'(count_r), 8);
    chk("wide8_ovf", int'(overflow), 0);
    vote(1, 1'b1);
    chk("sat_blue_b", int'(s_count_b), 1);
    chk("sat_blue_t", int'(s_count_t), 7);
    chk("sat_blue_ovf", int'(s_overflow), 1);
    chk("wide_blue_t", int'(count_t), 9);

    // Random traffic against the model.
    do_reset();
    check_model();
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      req    = 4'($urandom_range(0, 15));
      cand   = 4'($urandom_range(0, 15));
      freeze = ($urandom_range(0, 7) == 0);
      step();
      check_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
